// File: rtl/sys_reset_ctrl_mc.sv
// sys_reset_ctrl_mc: merges maskable reset requests and Hot-Spare-Boot into one
// minimum-width PCH system reset, records a sticky reset cause, and sequences
// the IO/PCIe reset channels off host platform reset. The channels are released
// in a staggered order, and FORCEPR is masked around each platform reset edge.
module sys_reset_ctrl_mc #(
  parameter int NUM_SRC                  = 4,
  parameter int NUM_IO                   = 4,
  parameter int MIN_PULSE_US             = 16,
  parameter int ASSERT_DLY_US            = 3,
  parameter int STAGGER_US               = 1,
  parameter int MAX_HSB_EVENTS_PER_RESET = 4,
  parameter int MAX_HSB_RST_ATTEMPT      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               t1us,
  input  logic               st_steady_pwrok,
  input  logic               rt_critical_fail_store,
  input  logic [NUM_SRC-1:0] rst_req_n,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               glp_bootnext_n,
  input  logic               hsb_en,
  input  logic               plt_rst_n,
  input  logic [NUM_IO-1:0]  rst_pcie_n,
  input  logic [NUM_IO-1:0]  io_en,
  input  logic               rst_cause_clr,
  output logic               pal_sys_reset,
  output logic               pal_sys_reset_n,
  output logic [NUM_SRC:0]   rst_cause,
  output logic               hsb_fail_n,
  output logic [NUM_IO-1:0]  rst_io_n,
  output logic               forcepr_mask
);

  // Width large enough to hold the value 'lim' itself (at least one bit).
  function automatic int clogb2(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

  localparam int EVT_W = clogb2(MAX_HSB_EVENTS_PER_RESET);
  localparam int ATT_W = clogb2(MAX_HSB_RST_ATTEMPT);
  localparam int PUL_W = clogb2(MIN_PULSE_US);
  localparam int DLY_W = clogb2(ASSERT_DLY_US);
  localparam int STG_W = clogb2((NUM_IO - 1) * STAGGER_US);

  localparam logic [EVT_W-1:0] EVT_LAST = EVT_W'(MAX_HSB_EVENTS_PER_RESET - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_HSB_RST_ATTEMPT);
  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(MIN_PULSE_US - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ASSERT_DLY_US - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'((NUM_IO - 1) * STAGGER_US);

  // Channels whose release time (k * STAGGER_US ticks) has been reached by tick count t.
  function automatic logic [NUM_IO-1:0] rel_due(input logic [STG_W-1:0] t);
    logic [NUM_IO-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_IO; k++) r[k] = (int'(t) >= k * STAGGER_US);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Hot-Spare-Boot: count BOOTNEXT falls, fire one forced reset per batch.
  // ---------------------------------------------------------------------------
  logic             boot_q;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic             hsb_fail_n_q, hsb_fail_n_d;
  logic             boot_fall, evt_clr, att_clr, hsb_req;

  assign boot_fall = boot_q & ~glp_bootnext_n;
  assign evt_clr   = ~hsb_en | ~st_steady_pwrok | ~plt_rst_n;
  assign att_clr   = ~hsb_en | ~st_steady_pwrok;
  // The request fires on the same clock as the fall that completes the batch.
  assign hsb_req   = boot_fall & ~evt_clr & (evt_q == EVT_LAST);

  // Event and attempt counters; both saturate, neither wraps.
  always_comb begin
    evt_d = evt_q;
    if (evt_clr || hsb_req)                 evt_d = '0;
    else if (boot_fall && evt_q != EVT_LAST) evt_d = evt_q + EVT_W'(1);

    att_d = att_q;
    if (att_clr)                           att_d = '0;
    else if (hsb_req && att_q != ATT_MAX)  att_d = att_q + ATT_W'(1);

    hsb_fail_n_d = (att_d < ATT_MAX);
  end

  // HSB state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      boot_q       <= 1'b1;
      evt_q        <= '0;
      att_q        <= '0;
      hsb_fail_n_q <= 1'b1;
    end else begin
      boot_q       <= glp_bootnext_n;
      evt_q        <= evt_d;
      att_q        <= att_d;
      hsb_fail_n_q <= hsb_fail_n_d;
    end
  end

  // ---------------------------------------------------------------------------
  // System reset: minimum-width pulse, stretched while any request persists.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLD} sys_st_t;

  sys_st_t          sys_q, sys_d;
  logic [PUL_W-1:0] pul_q, pul_d;
  logic             pal_q;
  logic [NUM_SRC:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] act_src;
  logic             req, cause_set;

  assign act_src = ~rst_req_n & src_en;
  assign req     = st_steady_pwrok & ((|act_src) | hsb_req);

  // Next state for the pulse FSM; loss of power-OK drops the reset unconditionally.
  always_comb begin
    sys_d     = sys_q;
    pul_d     = pul_q;
    cause_set = 1'b0;
    unique case (sys_q)
      S_IDLE: begin
        if (req) begin
          sys_d     = S_PULSE;
          pul_d     = '0;
          cause_set = 1'b1;
        end
      end
      S_PULSE: begin
        if (t1us) begin
          if (pul_q == PUL_LAST) sys_d = S_HOLD;
          else                   pul_d = pul_q + PUL_W'(1);
        end
      end
      S_HOLD: begin
        if (!req) sys_d = S_IDLE;
      end
      default: sys_d = S_IDLE;
    endcase
    if (!st_steady_pwrok) begin
      sys_d     = S_IDLE;
      cause_set = 1'b0;
    end
  end

  // Cause bits: a clear in the same cycle as a new set drops only the old bits.
  always_comb begin
    cause_d = rst_cause_clr ? '0 : cause_q;
    if (cause_set) cause_d = cause_d | {hsb_req, act_src};
  end

  // Pulse FSM and cause registers; the cause survives power loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      sys_q   <= S_IDLE;
      pul_q   <= '0;
      pal_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      sys_q   <= sys_d;
      pul_q   <= pul_d;
      pal_q   <= (sys_d != S_IDLE);
      cause_q <= cause_d;
    end
  end

  // ---------------------------------------------------------------------------
  // IO reset sequencer: staggered release, FORCEPR mask window, delayed assert.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {IO_RST, IO_REL, IO_MASK, IO_RUN, IO_ADLY} io_st_t;

  io_st_t            io_q, io_d;
  logic [NUM_IO-1:0] rel_q, rel_d;
  logic [STG_W-1:0]  stg_q, stg_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              mask_q, mask_d;
  logic [NUM_IO-1:0] io_n_q;

  // Next state for the IO sequencer; a fault or power loss forces immediate reset.
  always_comb begin
    io_d   = io_q;
    rel_d  = rel_q;
    stg_d  = stg_q;
    dly_d  = dly_q;
    mask_d = mask_q;
    unique case (io_q)
      IO_RST: begin
        rel_d  = '0;
        mask_d = 1'b1;
        if (plt_rst_n) begin
          io_d  = IO_REL;
          stg_d = '0;
          rel_d = rel_due('0);
        end
      end
      IO_REL: begin
        if (!plt_rst_n) begin
          io_d   = IO_ADLY;
          dly_d  = '0;
          mask_d = 1'b1;
        end else begin
          if (t1us && stg_q != STG_LAST) stg_d = stg_q + STG_W'(1);
          rel_d = rel_q | rel_due(stg_d);
          if (&rel_d) begin
            io_d  = IO_MASK;
            dly_d = '0;
          end
        end
      end
      IO_MASK: begin
        if (!plt_rst_n) begin
          io_d   = IO_ADLY;
          dly_d  = '0;
          mask_d = 1'b1;
        end else if (t1us) begin
          if (dly_q == DLY_LAST) begin
            io_d   = IO_RUN;
            mask_d = 1'b0;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
      end
      IO_RUN: begin
        if (!plt_rst_n) begin
          io_d   = IO_ADLY;
          dly_d  = '0;
          mask_d = 1'b1;
        end
      end
      IO_ADLY: begin
        // Runs to completion even if plt_rst_n returns, so no glitch release.
        mask_d = 1'b1;
        if (t1us) begin
          if (dly_q == DLY_LAST) begin
            io_d  = IO_RST;
            rel_d = '0;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
        end
      end
      default: begin
        io_d   = IO_RST;
        rel_d  = '0;
        mask_d = 1'b1;
      end
    endcase
    if (rt_critical_fail_store || !st_steady_pwrok) begin
      io_d   = IO_RST;
      rel_d  = '0;
      mask_d = 1'b1;
    end
  end

  // IO sequencer registers; pin drivers come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_q   <= IO_RST;
      rel_q  <= '0;
      stg_q  <= '0;
      dly_q  <= '0;
      mask_q <= 1'b1;
      io_n_q <= '0;
    end else begin
      io_q   <= io_d;
      rel_q  <= rel_d;
      stg_q  <= stg_d;
      dly_q  <= dly_d;
      mask_q <= mask_d;
      io_n_q <= rel_d & rst_pcie_n & io_en;
    end
  end

  assign pal_sys_reset   = pal_q;
  assign pal_sys_reset_n = ~pal_q;
  assign rst_cause       = cause_q;
  assign hsb_fail_n      = hsb_fail_n_q;
  assign rst_io_n        = io_n_q;
  assign forcepr_mask    = mask_q;

endmodule

// File: tb/tb_sys_reset_ctrl_mc.sv
// Directed bench for sys_reset_ctrl_mc with a per-cycle reference model.
module tb_sys_reset_ctrl_mc;
  localparam int NS = 4, NI = 4, MINP = 16, ADLY = 3, STG = 1, MAXEV = 4, MAXAT = 1;
  localparam int TDIV = 4;                     // clocks per t1us tick
  localparam int LAST = (NI - 1) * STG;        // tick of last channel release

  logic clk = 1'b0;
  logic reset, t1us, pwrok, crit, glp, hsb_en, plt, clr;
  logic [NS-1:0] req_n, src_en;
  logic [NI-1:0] pcie_n, io_en;
  logic pal, pal_n, fail_n, mask;
  logic [NS:0] cause;
  logic [NI-1:0] io;

  int n_chk = 0, n_pass = 0;
  int w, tk, guard;
  int rel_at [NI];

  always #5 clk = ~clk;

  sys_reset_ctrl_mc #(
    .NUM_SRC(NS), .NUM_IO(NI), .MIN_PULSE_US(MINP), .ASSERT_DLY_US(ADLY), .STAGGER_US(STG),
    .MAX_HSB_EVENTS_PER_RESET(MAXEV), .MAX_HSB_RST_ATTEMPT(MAXAT)
  ) dut (
    .clk(clk), .reset(reset), .t1us(t1us), .st_steady_pwrok(pwrok),
    .rt_critical_fail_store(crit), .rst_req_n(req_n), .src_en(src_en),
    .glp_bootnext_n(glp), .hsb_en(hsb_en), .plt_rst_n(plt), .rst_pcie_n(pcie_n),
    .io_en(io_en), .rst_cause_clr(clr), .pal_sys_reset(pal), .pal_sys_reset_n(pal_n),
    .rst_cause(cause), .hsb_fail_n(fail_n), .rst_io_n(io), .forcepr_mask(mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Free-running 1us strobe, one clock every TDIV clocks.
  int tdiv = 0;
  initial begin
    t1us = 1'b0;
    forever begin
      @(posedge clk); #1;
      tdiv = (tdiv + 1) % TDIV;
      t1us = (tdiv == 0);
    end
  end

  // ---------------- reference model ----------------
  bit m_ok = 0;
  bit m_boot, m_pal, m_fail_n, m_mask;
  int m_evt, m_att, m_pt, m_phase, m_up, m_dn;   // phase: 0 held, 1 coming up, 2 going down
  logic [NS:0] m_cause;
  logic [NI-1:0] m_rel, m_io;

  always @(posedge clk) begin : mdl
    logic hreq, rq;
    logic [NS-1:0] act;
    if (reset) begin
      m_boot = 1; m_evt = 0; m_att = 0; m_fail_n = 1; m_pal = 0; m_pt = 0; m_cause = '0;
      m_phase = 0; m_up = 0; m_dn = 0; m_rel = '0; m_mask = 1; m_io = '0;
    end else begin
      act  = ~req_n & src_en;
      hreq = 0;
      if (!hsb_en || !pwrok || !plt) m_evt = 0;
      else if (m_boot && !glp) begin
        m_evt++;
        if (m_evt == MAXEV) begin m_evt = 0; hreq = 1; end
      end
      m_boot = glp;
      if (!hsb_en || !pwrok) m_att = 0;
      else if (hreq && m_att < MAXAT) m_att++;
      m_fail_n = (m_att < MAXAT);

      rq = pwrok && ((act != 0) || hreq);
      if (clr) m_cause = '0;
      if (!pwrok) m_pal = 0;
      else if (!m_pal) begin
        if (rq) begin m_pal = 1; m_pt = 0; m_cause = m_cause | {hreq, act}; end
      end else if (m_pt < MINP) begin
        if (t1us) m_pt++;
      end else if (!rq) m_pal = 0;

      if (crit || !pwrok) begin
        m_phase = 0; m_rel = '0; m_mask = 1;
      end else begin
        case (m_phase)
          0: begin
            m_rel = '0; m_mask = 1;
            if (plt) begin
              m_phase = 1; m_up = 0;
              for (int k = 0; k < NI; k++) m_rel[k] = (m_up >= k * STG);
            end
          end
          1: begin
            if (!plt) begin m_phase = 2; m_dn = 0; m_mask = 1; end
            else begin
              if (t1us && m_up < LAST + ADLY) m_up++;
              for (int k = 0; k < NI; k++) m_rel[k] = (m_up >= k * STG);
              m_mask = (m_up < LAST + ADLY);
            end
          end
          default: begin
            if (t1us) begin
              m_dn++;
              if (m_dn == ADLY) begin m_rel = '0; m_phase = 0; end
            end
          end
        endcase
      end
      m_io = m_rel & pcie_n & io_en;
    end
    m_ok = 1;
  end

  // Every cycle: all outputs against the model.
  always @(negedge clk)
    if (m_ok)
      chk("model_cmp", {19'd0, pal, pal_n, cause, fail_n, io, mask},
          {19'd0, m_pal, ~m_pal, m_cause, m_fail_n, m_io, m_mask});

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bootfall();
    glp = 1'b0; step(2); glp = 1'b1; step(2);
  endtask

  // Width of the next pal_sys_reset pulse, in t1us ticks seen while it is high.
  task automatic measure_pulse(output int ticks);
    int g;
    ticks = 0; g = 0;
    while (pal !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    if (pal !== 1'b1) chk("pulse_start", {31'd0, pal}, 32'd1);
    else begin
      g = 0;
      while (pal === 1'b1 && g < 2000) begin
        if (t1us) ticks++;
        @(negedge clk); g++;
      end
      if (pal === 1'b1) chk("pulse_end", {31'd0, pal}, 32'd0);
    end
  endtask

  task automatic expect_no_pulse(input string name, input int n);
    logic hi;
    hi = 1'b0;
    repeat (n) begin @(negedge clk); if (pal) hi = 1'b1; end
    chk(name, {31'd0, hi}, 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1; pwrok = 0; crit = 0; glp = 1; hsb_en = 1; plt = 0; clr = 0;
    req_n = '1; src_en = '1; pcie_n = '1; io_en = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {19'd0, pal, pal_n, cause, fail_n, io, mask}, {19'd0, 13'b0_1_00000_1_0000_1});
    step(1); reset = 0; pwrok = 1; step(2);

    // 1: short request still gives the full minimum pulse
    fork
      begin req_n[0] = 0; step(2 * TDIV); req_n[0] = 1; end
      measure_pulse(w);
    join
    chk("t1_width", w, 16);
    chk("t1_cause", {27'd0, cause}, 32'b00001);

    // 2: clear, masked source ignored, long request stretches the pulse
    step(1); clr = 1; step(1); clr = 0;
    @(negedge clk); chk("t2_clr", {27'd0, cause}, 32'd0);
    src_en[1] = 0; req_n[1] = 0;
    expect_no_pulse("t2_masked", 20);
    req_n[1] = 1;
    chk("t2_cause_masked", {27'd0, cause}, 32'd0);
    step(1);
    fork
      begin req_n[2] = 0; step(40 * TDIV); req_n[2] = 1; end
      measure_pulse(w);
    join
    chk("t2_width", w, 40);
    chk("t2_cause", {27'd0, cause}, 32'b00100);

    // 4: platform reset release, staggered channels, mask window
    step(1); plt = 1;
    @(posedge clk);
    tk = 0; guard = 0;
    for (int k = 0; k < NI; k++) rel_at[k] = -1;
    while (guard < 200) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (io[k] && rel_at[k] < 0) rel_at[k] = tk;
      if (!mask) break;
      if (t1us) tk++;
      guard++;
    end
    for (int k = 0; k < NI; k++) chk($sformatf("t4_rel%0d", k), rel_at[k], k);
    chk("t4_mask_tick", tk, 6);
    chk("t4_mask", {31'd0, mask}, 32'd0);
    chk("t4_io", {28'd0, io}, 32'hF);

    // 3: four BOOTNEXT falls force one minimum reset and exhaust the budget
    step(1);
    fork
      begin repeat (4) bootfall(); end
      measure_pulse(w);
    join
    chk("t3_width", w, 16);
    chk("t3_cause", {27'd0, cause}, 32'b10100);
    chk("t3_fail", {31'd0, fail_n}, 32'd0);

    // 5: disabled channel stays low; platform fall masks at once, asserts after 3 ticks
    step(1); io_en[2] = 0; step(2);
    @(negedge clk); chk("t5_io_en", {28'd0, io}, 32'hB);
    step(1);
    repeat (3) bootfall();
    plt = 0;
    @(posedge clk); @(negedge clk);
    chk("t5_mask_on", {31'd0, mask}, 32'd1);
    fork
      begin step(2); plt = 1; bootfall(); end
      begin
        tk = 0; guard = 0;
        while (io != '0 && guard < 200) begin
          if (t1us) tk++;
          @(negedge clk); guard++;
        end
      end
    join
    chk("t5_assert_tick", tk, 3);
    expect_no_pulse("t3_no_hsb", 30);
    chk("t3_fail_hold", {31'd0, fail_n}, 32'd0);
    step(1); hsb_en = 0; step(1);
    @(negedge clk); chk("t3_fail_clr", {31'd0, fail_n}, 32'd1);
    step(1); hsb_en = 1;

    // 6: critical fault mid-release, power loss mid-pulse
    step(40); plt = 0; step(20); plt = 1;
    guard = 0;
    while (io[1] !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    chk("t6_rel1", {31'd0, io[1]}, 32'd1);
    crit = 1;
    @(posedge clk); @(negedge clk);
    chk("t6_crit_io", {28'd0, io}, 32'd0);
    chk("t6_crit_mask", {31'd0, mask}, 32'd1);
    step(2); crit = 0; step(10);
    req_n[3] = 0; step(5);
    @(negedge clk); chk("t6_pulse_on", {31'd0, pal}, 32'd1);
    pwrok = 0;
    @(posedge clk); @(negedge clk);
    chk("t6_pwrok_drop", {31'd0, pal}, 32'd0);
    req_n[3] = 1;
    chk("t6_cause", {27'd0, cause}, 32'b11100);
    step(3); pwrok = 1; step(3);

    // clear coinciding with a new set keeps only the new source
    src_en[1] = 1; req_n[1] = 0; clr = 1; step(1); clr = 0;
    @(negedge clk); chk("t7_clr_set", {27'd0, cause}, 32'b00010);
    step(8); req_n[1] = 1; step(100);
    @(negedge clk); chk("t7_pulse_done", {31'd0, pal}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1);
  end
endmodule
